// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: fetch PC, imem handshake, skid buffer, IF/ID register.
// Optional macro FETCH_PERF_EN adds accept and wait-cycle performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_4000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        npc_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic [31:0]        pc_o,
    fetch_stage_if.master      imem,
    output logic [31:0]        d_instr_o,
    output logic [31:0]        d_pc_o,
    output logic               d_valid_o,
    output logic               d_adel_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched_o,
    output logic [31:0]        perf_wait_o
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        skid_adel_q, skid_adel_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic        d_valid_q, d_valid_d;
    logic        d_adel_q, d_adel_d;
    logic        resp_vld_s;
    logic [31:0] resp_instr_s;
    logic        resp_adel_s;
    logic        accept_s;

    function automatic logic pc_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc >= IMEM_BASE) && ((pc - IMEM_BASE) < IMEM_BYTES);
    endfunction

    // Next-state, response selection, PC advance and IF/ID load
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_adel_d  = skid_adel_q;
        d_instr_d    = d_instr_q;
        d_pc_d       = d_pc_q;
        d_valid_d    = d_valid_q;
        d_adel_d     = d_adel_q;
        resp_vld_s   = 1'b0;
        resp_instr_s = skid_instr_q;
        resp_adel_s  = skid_adel_q;

        // An illegal PC never reaches memory; it answers at once with an AdEL bubble word.
        case (state_q)
            S_REQ: begin
                if (!pc_legal(pc_q)) begin
                    resp_vld_s   = 1'b1;
                    resp_instr_s = 32'h0000_0000;
                    resp_adel_s  = 1'b1;
                end else if (req_q && imem.gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    resp_vld_s   = 1'b1;
                    resp_instr_s = imem.rdata;
                    resp_adel_s  = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                resp_vld_s = 1'b1;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        accept_s = resp_vld_s && !stall_i;

        if (accept_s) begin
            pc_d    = npc_i;
            state_d = S_REQ;
        end else if (resp_vld_s && (state_q != S_HOLD)) begin
            skid_instr_d = resp_instr_s;
            skid_adel_d  = resp_adel_s;
            state_d      = S_HOLD;
        end else begin
            pc_d = pc_q;
        end

        if (flush_i) begin
            d_valid_d = 1'b0;
            d_instr_d = 32'h0000_0000;
            d_adel_d  = 1'b0;
        end else if (stall_i) begin
            d_valid_d = d_valid_q;
        end else if (accept_s) begin
            d_instr_d = resp_instr_s;
            d_pc_d    = pc_q;
            d_valid_d = 1'b1;
            d_adel_d  = resp_adel_s;
        end else begin
            d_valid_d = 1'b0;
            d_instr_d = 32'h0000_0000;
        end

        req_d = (state_d == S_REQ) && pc_legal(pc_d);
    end

    // State, PC, skid buffer and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            skid_instr_q <= 32'h0000_0000;
            skid_adel_q  <= 1'b0;
            d_instr_q    <= 32'h0000_0000;
            d_pc_q       <= 32'h0000_0000;
            d_valid_q    <= 1'b0;
            d_adel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            skid_instr_q <= skid_instr_d;
            skid_adel_q  <= skid_adel_d;
            d_instr_q    <= d_instr_d;
            d_pc_q       <= d_pc_d;
            d_valid_q    <= d_valid_d;
            d_adel_q     <= d_adel_d;
        end
    end

    assign pc_o      = pc_q;
    assign imem.req  = req_q;
    assign imem.addr = pc_q;
    assign d_instr_o = d_instr_q;
    assign d_pc_o    = d_pc_q;
    assign d_valid_o = d_valid_q;
    assign d_adel_o  = d_adel_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    // Counter increments; both wrap naturally at 2^32
    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, accept_s};
        perf_wait_d    = perf_wait_q + {31'd0, (state_q == S_WAIT) && !imem.rvalid};
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_wait_q    <= 32'h0000_0000;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_wait_q    <= perf_wait_d;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_wait_o    = perf_wait_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a flag-based reference model of the fetch
// pipeline predicts every output each cycle; includes mid-fetch async reset.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic [31:0] pc_o;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic        d_valid;
    logic        d_adel;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_wait;
`endif

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .npc_i     (npc),
        .stall_i   (stall),
        .flush_i   (flush),
        .pc_o      (pc_o),
        .imem      (imem_bus),
        .d_instr_o (d_instr),
        .d_pc_o    (d_pc),
        .d_valid_o (d_valid),
        .d_adel_o  (d_adel)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o (perf_fetched),
        .perf_wait_o    (perf_wait)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_have;
    bit          m_req_ok;
    logic [31:0] m_hold_instr;
    bit          m_hold_adel;
    logic [31:0] m_d_instr;
    logic [31:0] m_d_pc;
    bit          m_d_valid;
    bit          m_d_adel;
    logic [31:0] m_fetched;
    logic [31:0] m_wait;
    logic [31:0] mem_addr;

    function automatic bit is_legal(input logic [31:0] a);
        longint unsigned v;
        v = a;
        return (v % 4 == 0) && (v >= 64'h3000) && (v < 64'h7000);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2408_0001;
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_out = 1'b0; m_have = 1'b0; m_req_ok = 1'b0;
        m_hold_instr = 32'd0; m_hold_adel = 1'b0;
        m_d_instr = 32'd0; m_d_pc = 32'd0; m_d_valid = 1'b0; m_d_adel = 1'b0;
        m_fetched = 32'd0; m_wait = 32'd0;
    endtask

    task automatic check_all(input bit exp_req);
        check_val("pc", pc_o, m_pc);
        check_val("req", {31'd0, imem_bus.req}, {31'd0, exp_req});
        if (exp_req) check_val("addr", imem_bus.addr, m_pc);
        check_val("d_instr", d_instr, m_d_instr);
        check_val("d_pc", d_pc, m_d_pc);
        check_val("d_valid", {31'd0, d_valid}, {31'd0, m_d_valid});
        check_val("d_adel", {31'd0, d_adel}, {31'd0, m_d_adel});
`ifdef FETCH_PERF_EN
        check_val("perf_fetched", perf_fetched, m_fetched);
        check_val("perf_wait", perf_wait, m_wait);
`endif
    endtask

    // One cycle: check at negedge, drive inputs, advance model, move to next negedge.
    // mode 0: zero-wait memory, sequential npc, no stall/flush. mode 1: random.
    task automatic step(input int mode);
        bit          exp_req, gnt, rvalid, resp;
        logic [31:0] rdata, ri;
        bit          ra;
        int          r;
        exp_req = m_req_ok && !m_out && !m_have && is_legal(m_pc);
        check_all(exp_req);

        if (mode == 0) begin
            stall = 1'b0; flush = 1'b0; npc = m_pc + 32'd4;
            gnt = imem_bus.req; rvalid = m_out;
        end else begin
            stall = ($urandom % 3) == 0;
            flush = ($urandom % 8) == 0;
            r = $urandom % 8;
            if (r < 5)       npc = m_pc + 32'd4;
            else if (r == 5) npc = 32'h0000_3000 + (($urandom % 32'h1000) * 32'd4);
            else if (r == 6) npc = 32'h0000_3002;
            else             npc = ($urandom % 2) ? 32'h0000_8000 : 32'h0000_2FFC;
            gnt    = imem_bus.req && ($urandom % 2);
            rvalid = m_out && ($urandom % 2);
        end
        if (gnt) mem_addr = imem_bus.addr;
        rdata = rvalid ? mem_word(mem_addr) : $urandom;
        imem_bus.gnt = gnt; imem_bus.rvalid = rvalid; imem_bus.rdata = rdata;

        resp = 1'b0; ri = 32'd0; ra = 1'b0;
        if (m_have) begin
            resp = 1'b1; ri = m_hold_instr; ra = m_hold_adel;
        end else if (m_out && rvalid) begin
            resp = 1'b1; ri = rdata; ra = 1'b0;
        end else if (!m_out && !is_legal(m_pc)) begin
            resp = 1'b1; ri = 32'd0; ra = 1'b1;
        end
        if (m_out && !rvalid) m_wait++;

        if (flush) begin
            m_d_valid = 1'b0; m_d_instr = 32'd0; m_d_adel = 1'b0;
        end else if (!stall && resp) begin
            m_d_valid = 1'b1; m_d_instr = ri; m_d_pc = m_pc; m_d_adel = ra;
        end else if (!stall) begin
            m_d_valid = 1'b0; m_d_instr = 32'd0;
        end

        if (resp && !stall) begin
            m_pc = npc; m_fetched++; m_have = 1'b0; m_out = 1'b0;
        end else if (resp) begin
            m_have = 1'b1; m_hold_instr = ri; m_hold_adel = ra; m_out = 1'b0;
        end else if (exp_req && gnt) begin
            m_out = 1'b1;
        end
        m_req_ok = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        check_val("rst_pc", pc_o, RESET_PC);
        check_val("rst_req", {31'd0, imem_bus.req}, 32'd0);
        check_val("rst_d_instr", d_instr, 32'd0);
        check_val("rst_d_pc", d_pc, 32'd0);
        check_val("rst_d_valid", {31'd0, d_valid}, 32'd0);
        check_val("rst_d_adel", {31'd0, d_adel}, 32'd0);
`ifdef FETCH_PERF_EN
        check_val("rst_perf_fetched", perf_fetched, 32'd0);
        check_val("rst_perf_wait", perf_wait, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; npc = 32'd0; stall = 1'b0; flush = 1'b0;
        imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'd0;
        mem_addr = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step(0);
        for (int i = 0; i < 700; i++) step(1);

        // Reset while a fetch is outstanding
        for (int i = 0; i < 50 && !m_out; i++) step(1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0;
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 12; i++) step(0);
        for (int i = 0; i < 1500; i++) step(1);
        for (int i = 0; i < 10; i++) step(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
